// File: rtl/mux_rr_arbiter_if.sv
// Bus bundle for the 4:1 round-robin mux arbiter: four requesters with
// their request lines and data words on one side, the granted select,
// one-hot grant and registered output word on the other.
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       REQ;
    logic [WIDTH-1:0] A0;
    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] A2;
    logic [WIDTH-1:0] A3;
    logic [1:0]       S;
    logic [3:0]       GNT;
    logic [WIDTH-1:0] Y;
    logic             VALID;
    logic             BUSY;

    // Requester side: drives requests and data, observes grant and output.
    modport master (
        output REQ, A0, A1, A2, A3,
        input  S, GNT, Y, VALID, BUSY
    );

    // Arbiter side: samples requests and data, drives grant and output.
    modport slave (
        input  REQ, A0, A1, A2, A3,
        output S, GNT, Y, VALID, BUSY
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4:1 word multiplexer.
// One requester holds the grant at a time; each transfer registers the
// selected word onto Y with a one-cycle VALID strobe. A grant is capped at
// MAX_BURST transfers whenever another requester is waiting. All outputs
// are registered, so there is no combinational input-to-output path.
module mux_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    mux_rr_arbiter_if.slave  bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       s_q, s_d;
    logic [1:0]       last_q, last_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             hold_q, hold_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] sel_word;
    logic [1:0]       pick;
    logic             others;
    logic [7:0]       cnt_inc;

    // First requester found searching last+1, last+2, last+3, last+4 (mod 4).
    // Scanning from the far end lets the nearest hit overwrite later ones.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] k);
        onehot = 4'b0001 << k;
    endfunction

    // Data mux steered by the registered select.
    always_comb begin
        case (s_q)
            2'd0:    sel_word = bus.A0;
            2'd1:    sel_word = bus.A1;
            2'd2:    sel_word = bus.A2;
            default: sel_word = bus.A3;
        endcase
    end

    // Arbitration helpers: next pick, competing requests, saturating count.
    always_comb begin
        pick    = rr_pick(bus.REQ, last_q);
        others  = |(bus.REQ & ~onehot(s_q));
        cnt_inc = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + 8'd1;
    end

    // Next-state logic for the IDLE/GRANT sequencer and its registered outputs.
    // hold marks the first edge after a burst-limit switch: that edge only
    // re-steers the mux, so exactly one VALID bubble separates the bursts.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        y_d     = y_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.REQ) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot(pick);
                    s_d     = pick;
                    last_d  = pick;
                    cnt_d   = 8'd0;
                    hold_d  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!bus.REQ[s_q]) begin
                    // Granted requester let go: hand over at once or go idle.
                    hold_d = 1'b0;
                    cnt_d  = 8'd0;
                    if (|bus.REQ) begin
                        gnt_d  = onehot(pick);
                        s_d    = pick;
                        last_d = pick;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    y_d     = sel_word;
                    valid_d = 1'b1;
                    if ((cnt_inc == MAX_CNT) && others) begin
                        // Burst limit hit with a waiter: pick is never s_q here.
                        gnt_d  = onehot(pick);
                        s_d    = pick;
                        last_d = pick;
                        cnt_d  = 8'd0;
                        hold_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
        busy_d = (state_d == ST_GRANT);
    end

    // State and output registers; reset drops any grant in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 4'b0000;
            s_q     <= 2'b00;
            last_q  <= 2'b11;
            cnt_q   <= 8'd0;
            hold_q  <= 1'b0;
            y_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.S     = s_q;
    assign bus.GNT   = gnt_q;
    assign bus.Y     = y_q;
    assign bus.VALID = valid_q;
    assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter with MAX_BURST=4: reset, single
// requester, round-robin fairness with wrap, early release, lone requester
// past the burst limit, and reset in the middle of a grant.
module tb_mux_rr_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    mux_rr_arbiter_if #(.WIDTH(8)) bus ();

    mux_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] gnt, input logic [1:0] s,
                           input logic [7:0] y, input logic valid, input logic busy);
        chk({tag, ".gnt"},   32'(bus.GNT),   32'(gnt));
        chk({tag, ".s"},     32'(bus.S),     32'(s));
        chk({tag, ".y"},     32'(bus.Y),     32'(y));
        chk({tag, ".valid"}, 32'(bus.VALID), 32'(valid));
        chk({tag, ".busy"},  32'(bus.BUSY),  32'(busy));
    endtask

    initial begin
        logic [7:0] words [4];
        logic [7:0] last_y;
        total  = 0;
        passed = 0;
        words[0] = 8'h01; words[1] = 8'h03; words[2] = 8'h07; words[3] = 8'h0F;
        bus.A0 = words[0]; bus.A1 = words[1]; bus.A2 = words[2]; bus.A3 = words[3];

        // Reset held two cycles with all requests up.
        rst = 1'b1;
        bus.REQ = 4'b1111;
        tick();
        tick();
        chk_out("reset", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("release", 4'b0001, 2'd0, 8'h00, 1'b0, 1'b1);

        // Single requester: three transfers then release.
        bus.REQ = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("single%0d", i), 4'b0001, 2'd0, 8'h01, 1'b1, 1'b1);
        end
        bus.REQ = 4'b0000;
        tick();
        chk_out("single_end", 4'b0000, 2'd0, 8'h01, 1'b0, 1'b0);

        // Fairness: restart from requester 0, all requests held.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.REQ = 4'b1111;
        tick();
        chk_out("fair_grant", 4'b0001, 2'd0, 8'h00, 1'b0, 1'b1);
        last_y = 8'h00;
        for (int g = 0; g < 5; g++) begin
            if (g > 0) begin
                tick();
                chk_out($sformatf("fair_bubble%0d", g), 4'(1 << (g % 4)), 2'(g % 4),
                        last_y, 1'b0, 1'b1);
            end
            for (int t = 0; t < 4; t++) begin
                tick();
                chk($sformatf("fair%0d_%0d.valid", g, t), 32'(bus.VALID), 32'd1);
                chk($sformatf("fair%0d_%0d.y", g, t), 32'(bus.Y), 32'(words[g % 4]));
            end
            last_y = words[g % 4];
            chk($sformatf("fair%0d.next_gnt", g), 32'(bus.GNT), 32'(1 << ((g + 1) % 4)));
            chk($sformatf("fair%0d.next_s", g), 32'(bus.S), 32'((g + 1) % 4));
        end
        // Granted requester 1 is in its bubble; dropping all requests idles.
        bus.REQ = 4'b0000;
        tick();
        chk_out("fair_idle", 4'b0000, 2'd1, 8'h01, 1'b0, 1'b0);

        // Early release: last grant was 1, so requester 2 wins next.
        bus.REQ = 4'b0100;
        tick();
        chk_out("early_grant", 4'b0100, 2'd2, 8'h01, 1'b0, 1'b1);
        bus.REQ = 4'b0101;
        tick();
        chk_out("early_x0", 4'b0100, 2'd2, 8'h07, 1'b1, 1'b1);
        tick();
        chk_out("early_x1", 4'b0100, 2'd2, 8'h07, 1'b1, 1'b1);
        bus.REQ = 4'b0001;
        tick();
        chk_out("early_switch", 4'b0001, 2'd0, 8'h07, 1'b0, 1'b1);
        tick();
        chk_out("early_r0", 4'b0001, 2'd0, 8'h01, 1'b1, 1'b1);
        bus.REQ = 4'b0000;
        tick();
        chk_out("early_idle", 4'b0000, 2'd0, 8'h01, 1'b0, 1'b0);

        // Lone requester 3 for ten cycles: grant, then nine transfers.
        bus.REQ = 4'b1000;
        tick();
        chk_out("lone_grant", 4'b1000, 2'd3, 8'h01, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_out($sformatf("lone%0d", i), 4'b1000, 2'd3, 8'h0F, 1'b1, 1'b1);
        end
        bus.REQ = 4'b1010;
        tick();
        chk_out("lone_switch", 4'b0010, 2'd1, 8'h0F, 1'b1, 1'b1);
        tick();
        chk_out("lone_bubble", 4'b0010, 2'd1, 8'h0F, 1'b0, 1'b1);
        tick();
        chk_out("lone_r1", 4'b0010, 2'd1, 8'h03, 1'b1, 1'b1);

        // Reset in the middle of requester 1's burst.
        rst = 1'b1;
        tick();
        chk_out("midrst", 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        bus.REQ = 4'b1111;
        tick();
        chk_out("midrst_grant", 4'b0001, 2'd0, 8'h00, 1'b0, 1'b1);
        tick();
        chk_out("midrst_x0", 4'b0001, 2'd0, 8'h01, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
